// File: rtl/alu_request_scheduler_if.sv
// Request, ALU and response channels of alu_request_scheduler.
// slave is the scheduler's view; master is the view of whatever surrounds it.
interface alu_request_scheduler_if #(
  parameter int OP_W = 3
);
  logic            req0Valid;
  logic            req0Ready;
  logic [OP_W-1:0] req0Op;
  logic [31:0]     req0OperandA;
  logic [3:0]      req0Imm;

  logic            req1Valid;
  logic            req1Ready;
  logic [OP_W-1:0] req1Op;
  logic [31:0]     req1OperandA;
  logic [3:0]      req1Imm;

  logic [OP_W-1:0] aluOp;
  logic [31:0]     aluA;
  logic [31:0]     aluB;
  logic            aluStart;
  logic            aluDone;
  logic [31:0]     aluResult;

  logic            rspValid;
  logic            rspReady;
  logic            rspId;
  logic [31:0]     rspResult;
  logic            rspError;

  modport slave (
    input  req0Valid, req0Op, req0OperandA, req0Imm,
    output req0Ready,
    input  req1Valid, req1Op, req1OperandA, req1Imm,
    output req1Ready,
    output aluOp, aluA, aluB, aluStart,
    input  aluDone, aluResult,
    output rspValid, rspId, rspResult, rspError,
    input  rspReady
  );

  modport master (
    output req0Valid, req0Op, req0OperandA, req0Imm,
    input  req0Ready,
    output req1Valid, req1Op, req1OperandA, req1Imm,
    input  req1Ready,
    input  aluOp, aluA, aluB, aluStart,
    output aluDone, aluResult,
    input  rspValid, rspId, rspResult, rspError,
    output rspReady
  );
endinterface

// File: rtl/alu_request_scheduler.sv
// Round-robin sharing of one ALU between two requesters with a tagged response channel.
// Define ALU_TIMEOUT_EN to add a watchdog that aborts a WAIT after TIMEOUT_CYCLES cycles.
module alu_request_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int          OP_W           = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_request_scheduler_if.slave bus,
  output logic                  busy,
  output logic [15:0]           completedCount
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  stateT           state;
  stateT           nextState;
  logic            rrPtr;
  logic            grantValid;
  logic            grantId;
  logic            waitExpire;
  logic [OP_W-1:0] opQ;
  logic [31:0]     aQ;
  logic [31:0]     bQ;
  logic            idQ;
  logic [31:0]     resultQ;
  logic [15:0]     completedCnt;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("alu_request_scheduler: TIMEOUT_CYCLES must be 1..255");
  end

`ifdef ALU_TIMEOUT_EN
  logic [7:0] wdCnt;
  logic       errQ;

  // Expiry is flagged in the last allowed WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES.
  assign waitExpire = (wdCnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdCnt <= 8'd0;
      errQ  <= 1'b0;
    end else begin
      if (state != WAIT) begin
        wdCnt <= 8'd0;
      end else if (!bus.aluDone) begin
        wdCnt <= wdCnt + 8'd1;
      end
      if (state == WAIT && (bus.aluDone || waitExpire)) begin
        errQ <= !bus.aluDone;
      end
    end
  end

  assign bus.rspError = errQ;
`else
  assign waitExpire   = 1'b0;
  assign bus.rspError = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    grantValid = 1'b0;
    grantId    = rrPtr;
    case (state)
      IDLE: begin
        grantValid = bus.req0Valid || bus.req1Valid;
        if (!(bus.req0Valid && bus.req1Valid)) begin
          grantId = bus.req1Valid;
        end
        if (grantValid) begin
          nextState = ISSUE;
        end
      end
      ISSUE: nextState = WAIT;
      WAIT: begin
        if (bus.aluDone || waitExpire) begin
          nextState = RESP;
        end
      end
      RESP: begin
        if (bus.rspReady) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // A granted requester is always valid, so grantValid doubles as the accept strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr        <= 1'b0;
      opQ          <= '0;
      aQ           <= 32'd0;
      bQ           <= 32'd0;
      idQ          <= 1'b0;
      resultQ      <= 32'd0;
      completedCnt <= 16'd0;
    end else begin
      if (grantValid) begin
        opQ   <= grantId ? bus.req1Op : bus.req0Op;
        aQ    <= grantId ? bus.req1OperandA : bus.req0OperandA;
        bQ    <= {28'd0, (grantId ? bus.req1Imm : bus.req0Imm)};
        idQ   <= grantId;
        rrPtr <= ~grantId;
      end
      if (state == WAIT) begin
        if (bus.aluDone) begin
          resultQ <= bus.aluResult;
        end else if (waitExpire) begin
          resultQ <= 32'd0;
        end
      end
      if (state == RESP && bus.rspReady) begin
        completedCnt <= completedCnt + 16'd1;
      end
    end
  end

  assign bus.req0Ready  = grantValid && !grantId;
  assign bus.req1Ready  = grantValid && grantId;
  assign bus.aluOp      = opQ;
  assign bus.aluA       = aQ;
  assign bus.aluB       = bQ;
  assign bus.aluStart   = (state == ISSUE);
  assign bus.rspValid   = (state == RESP);
  assign bus.rspId      = idQ;
  assign bus.rspResult  = resultQ;
  assign busy           = (state != IDLE);
  assign completedCount = completedCnt;

endmodule

// File: doc/alu_request_scheduler.md
Name: alu_request_scheduler

Overview:
Shares the single 32-bit ALU between two requesters (e.g. decode path and test/debug port). Arbitrates round-robin, latches the winner's opcode and operand A, and zero-extends its 4-bit immediate to 32 bits as operand B. It then sequences the ALU through a start/done handshake and returns the result on a response channel tagged with the requester ID.

Parameters:
TIMEOUT_CYCLES, 16, WAIT cycles before watchdog abort (used only with ALU_TIMEOUT_EN); legal 1..255
OP_W, 3, ALU opcode width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0Valid  in  1  requester 0 has a request
req0Ready  out  1  requester 0 request accepted this cycle if valid
req0Op  in  OP_W  requester 0 opcode
req0OperandA  in  32  requester 0 operand A
req0Imm  in  4  requester 0 immediate (zero-extended to operand B)
req1Valid / req1Ready / req1Op / req1OperandA / req1Imm  same as requester 0
aluOp  out  OP_W  opcode to ALU
aluA  out  32  operand A to ALU
aluB  out  32  zero-extended immediate to ALU
aluStart  out  1  one-cycle start pulse
aluDone  in  1  ALU result valid
aluResult  in  32  ALU result
rspValid  out  1  response valid
rspReady  in  1  response consumer ready
rspId  out  1  requester that owns the response
rspResult  out  32  captured result
rspError  out  1  response aborted by watchdog
busy  out  1  state != IDLE
completedCount  out  16  responses delivered, wraps 0xFFFF->0x0000

Behaviour:
- Reset (async, rst_n=0): state IDLE, rrPtr=0, all outputs and internal registers 0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: grant computed combinationally. Only one valid -> that requester. Both valid -> requester rrPtr. reqXReady=1 only in IDLE and only for granted X; both readys 0 in all other states.
- Accept (reqXValid&&reqXReady): latch op, operand A, aluB={28'b0,imm}, rspId=X; rrPtr<=~X; go ISSUE.
- ISSUE: aluStart=1 for exactly this cycle; go WAIT. aluOp/aluA/aluB held stable from ISSUE until WAIT exits.
- WAIT: aluDone sampled only here (ignored in all other states). On aluDone=1: rspResult<=aluResult, rspError<=0; go RESP.
- RESP: rspValid=1; rspId/rspResult/rspError stable until rspReady=1.
- Response handshake: completedCount+1 (wraps); go IDLE. Next accept earliest the following cycle.
- Minimum latency: accept edge -> rspValid high = 3 cycles (aluDone in first WAIT cycle). Throughput: one op per 4 cycles maximum.
- Requests arriving while busy are held by the requester (valid must stay high until ready); no queueing inside the block.
- rst_n asserted mid-operation: operation abandoned, no response, counter cleared.

Optional Feature:
ALU_TIMEOUT_EN
- Defined: 8-bit watchdog counter cleared on entering WAIT, incremented each WAIT cycle without aluDone. When the count reaches TIMEOUT_CYCLES: go RESP with rspResult=0, rspError=1. aluDone in the same cycle as expiry takes priority (normal result, rspError=0). Aborted responses still increment completedCount.
- Undefined: no counter; WAIT waits indefinitely; rspError tied 0.

Test Plan:
- Single request: req0 op=3'd2, A=0x0000_0010, imm=4'hF; ALU done after 1 WAIT cycle with result 0x1F -> aluB=0x0000_000F, one aluStart pulse, rspValid 3 cycles after accept, rspId=0, rspResult=0x0000_001F, completedCount=1.
- Contention: req0 and req1 held valid for 4 ops -> grants alternate 0,1,0,1 starting from rrPtr=0; rspId sequence 0,1,0,1.
- Backpressure: rspReady=0 for 5 cycles in RESP -> rspValid, rspResult, rspId stable; both readys 0; no new accept until the cycle after rspReady=1.
- Reset mid-WAIT: drop rst_n during WAIT -> outputs 0 immediately; after release, state IDLE, no response issued, completedCount=0.
- Counter wrap: preload via 65536 completions (or forced) -> completedCount 0xFFFF -> 0x0000.
- ALU_TIMEOUT_EN, TIMEOUT_CYCLES=4, aluDone never asserted -> rspValid with rspError=1 and rspResult=0 after 4 WAIT cycles. Repeat with aluDone on the expiry cycle -> rspError=0, rspResult=aluResult.
